// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, done strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx #(
    parameter int BIT_CNT_MAX = 9,
    parameter int MID_CNT     = BIT_CNT_MAX / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       rx_done_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam logic [15:0] C_END = 16'(BIT_CNT_MAX);
    localparam logic [15:0] C_MID = 16'(MID_CNT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [5:0] {
        s_idle  = 6'b000001,
        s_start = 6'b000010,
        s_data  = 6'b000100,
        s_par   = 6'b001000,
        s_stop  = 6'b010000,
        s_done  = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        s_idle  = 5'b00001,
        s_start = 5'b00010,
        s_data  = 5'b00100,
        s_stop  = 5'b01000,
        s_done  = 5'b10000
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_s_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shreg;
    logic        r_stop;
    logic        w_fall;
    logic        w_mid;
    logic        w_end;
    logic        w_shift;
    logic        w_latch_stop;
    logic        w_done;

    assign w_fall = ~r_rx_s & r_rx_s_d;
    assign w_mid  = (r_cnt == C_MID);
    assign w_end  = (r_cnt == C_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync1  <= rx_i;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= s_idle;
        else        r_state <= w_next;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_latch_par;
`endif

    always_comb begin
        w_next       = r_state;
        w_shift      = 1'b0;
        w_latch_stop = 1'b0;
        w_done       = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_latch_par  = 1'b0;
`endif
        case (r_state)
            s_idle: begin
                if (w_fall) w_next = s_start;
            end
            s_start: begin
                // Line back high at mid-bit: treat as a glitch.
                if (w_mid && r_rx_s)  w_next = s_idle;
                else if (w_end)       w_next = s_data;
            end
            s_data: begin
                w_shift = w_mid;
                if (w_end && r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_next = s_par;
`else
                    w_next = s_stop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            s_par: begin
                w_latch_par = w_mid;
                if (w_end) w_next = s_stop;
            end
`endif
            s_stop: begin
                if (w_mid) begin
                    w_latch_stop = 1'b1;
                    w_next       = s_done;
                end
            end
            s_done: begin
                w_done = 1'b1;
                w_next = s_idle;
            end
            default: w_next = s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == s_idle || r_state == s_done ||
                     w_next != r_state || w_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shreg <= '0;
            r_stop  <= 1'b1;
        end else begin
            if (r_state != s_data) r_idx <= '0;
            else if (w_end)        r_idx <= r_idx + 3'd1;
            if (w_shift)      r_shreg <= {r_rx_s, r_shreg[7:1]};
            if (w_latch_stop) r_stop  <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_o   <= 1'b0;
            data_o      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            rx_done_o <= w_done;
            if (w_done) begin
                data_o      <= r_shreg;
                frame_err_o <= ~r_stop;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par        <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (w_latch_par) r_par <= r_rx_s;
            if (w_done)      parity_err_o <= ^r_shreg ^ r_par;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random traffic, compared
// against an expected-event queue built from frame-level rules.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int LAT = 108;
`else
    localparam bit PAR = 1'b0;
    localparam int LAT = 98;
`endif
    localparam int BITLEN = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       rx_done_o;
    logic       frame_err_o;
    logic       parity_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    uart_rx #(.BIT_CNT_MAX(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .rx_done_o    (rx_done_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (rx_done_o === 1'b1) begin
            e.t  = cyc;
            e.d  = data_o;
            e.fe = frame_err_o;
            e.pe = parity_err_o;
            got_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit is first sampled at the next posedge (edge 0).
    task automatic send(input logic [7:0] b, input logic stopb,
                        input logic pbit);
        ev_t e;
        e.t  = cyc + 1 + LAT;
        e.d  = b;
        e.fe = ~stopb;
        e.pe = PAR ? (^b ^ pbit) : 1'b0;
        exp_q.push_back(e);
        hold(1'b0, BITLEN);
        for (int i = 0; i < 8; i++) hold(b[i], BITLEN);
        if (PAR) hold(pbit, BITLEN);
        hold(stopb, BITLEN);
    endtask

    task automatic verify(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            ev_t g;
            ev_t x;
            g = got_q.pop_front();
            x = exp_q.pop_front();
            chk({tag, "_time"}, g.t, x.t);
            chk({tag, "_data"}, g.d, x.d);
            chk({tag, "_ferr"}, g.fe, x.fe);
            chk({tag, "_perr"}, g.pe, x.pe);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_done"}, rx_done_o, 0);
        chk({tag, "_ferr"}, frame_err_o, 0);
        chk({tag, "_perr"}, parity_err_o, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       p;
        logic [7:0] pb;

        rst_n = 1'b0;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;

        hold(1'b1, 200);
        verify("idle");
        chk("idle_data", data_o, 0);

        send(8'hA5, 1'b1, ^8'hA5);
        hold(1'b1, 20);
        verify("a5");
        chk("a5_hold", data_o, 8'hA5);

        send(8'h3C, 1'b1, ^8'h3C);
        send(8'hC3, 1'b1, ^8'hC3);
        hold(1'b1, 20);
        verify("b2b");

        hold(1'b0, 3);
        hold(1'b1, 20);
        send(8'h55, 1'b1, ^8'h55);
        hold(1'b1, 20);
        verify("glitch");

        send(8'hFF, 1'b0, ^8'hFF);
        hold(1'b0, 50);
        verify("ferr");
        chk("ferr_flag", frame_err_o, 1);
        chk("ferr_data", data_o, 8'hFF);
        hold(1'b1, 20);
        verify("ferr_high");
        send(8'h12, 1'b1, ^8'h12);
        hold(1'b1, 20);
        verify("after_ferr");

        pb = 8'h6B;
        hold(1'b0, BITLEN);
        for (int i = 0; i < 4; i++) hold(pb[i], BITLEN);
        hold(pb[4], 5);
        rst_n = 1'b0;
        rx_i  = 1'b1;
        @(negedge clk);
        chk_cleared("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 20);
        verify("rst_mid");
        send(8'h81, 1'b1, ^8'h81);
        hold(1'b1, 20);
        verify("after_rst");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        hold(1'b1, 20);
        verify("par_ok");
        chk("par_ok_flag", parity_err_o, 0);
        send(8'h07, 1'b1, 1'b0);
        hold(1'b1, 20);
        verify("par_bad");
        chk("par_bad_flag", parity_err_o, 1);
`endif

        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^b) : ^b;
            send(b, 1'b1, p);
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 20);
        verify("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Oversamples the serial line rx_i with the system clock, one bit period = BIT_CNT_MAX+1 clocks, and samples each bit at mid-period.
- Delivers the byte on data_o with a one-cycle rx_done_o strobe, plus framing/parity status.
- Sits between the board RX pin and the byte-level consumer logic.

Parameters:
- BIT_CNT_MAX, 9, clocks per bit minus 1. Simulation value is 9; the 50 MHz / 9600 baud build uses 5207.
- MID_CNT, BIT_CNT_MAX/2 (integer division), counter value at which a bit is sampled.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line; asynchronous to clk; idles high.
- data_o  output  8  last received byte, LSB first on the line.
- rx_done_o  output  1  one-cycle strobe; data_o and the error flags are valid from this cycle.
- frame_err_o  output  1  stop bit sampled low for the frame just reported.
- parity_err_o  output  1  parity mismatch for the frame just reported; constant 0 when the parity option is out.

Behaviour:
- Reset (asynchronous, any state, mid-frame included): state=s_idle, cnt=0, data_o=0, rx_done_o=0, frame_err_o=0, parity_err_o=0. Both synchronizer flops and the edge-delay flop reset to 1. A partial frame is discarded.
- Input path: rx_i -> sync1 -> rx_s (2-flop synchronizer) -> rx_s_d (1 delay flop). fall = rx_s & ~rx_s_d... specifically fall = ~rx_s & rx_s_d.
- Bit counter cnt, 16 bits:
  - Cleared in s_idle and s_done, and on every state change.
  - Otherwise increments each clock; wraps to 0 after BIT_CNT_MAX.
- States (one-hot): s_idle, s_start, s_data, s_par (option only), s_stop, s_done.
  - s_idle: on fall -> s_start with cnt=0.
  - s_start: at cnt==MID_CNT, if rx_s==1 the start was false -> s_idle, with no strobe and no flag change. At cnt==BIT_CNT_MAX -> s_data.
  - s_data: at cnt==MID_CNT, shift rx_s into the shift register LSB first (shreg <= {rx_s, shreg[7:1]}). A 3-bit bit index counts 0..7. At cnt==BIT_CNT_MAX with index 7 -> s_par if the option is in, else s_stop; otherwise the index increments.
  - s_stop: at cnt==MID_CNT, latch stop bit = rx_s -> s_done. The receiver does not wait out the rest of the stop bit, so it can re-arm early for back-to-back frames.
  - s_done: one cycle. rx_done_o<=1, data_o<=shreg, frame_err_o<=~stop bit, parity_err_o updated. -> s_idle.
  - rx_done_o is 0 in every other cycle.
- data_o and the error flags hold their values until the next s_done. They are updated even when a framing error occurs.
- After a framing error the line may still be low. Re-arming needs a new high-to-low transition, so no false frame is generated from a stuck-low line.
- A glitch on rx_i shorter than MID_CNT clocks is rejected by the start-bit check.
- Latency with BIT_CNT_MAX=9, parity out: rx_done_o is high exactly after the 98th rising edge, counting the first edge that samples rx_i low as edge 0.
- Unused state encodings -> s_idle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. State s_par is entered after data bit 7. It samples the parity bit at MID_CNT and leaves for s_stop at BIT_CNT_MAX. In s_done, parity_err_o <= ^shreg ^ parity bit (even parity). Latency becomes 108 edges.
- Not defined: s_par and its logic are absent, and parity_err_o is tied to 0.

Test Plan:
- Reset, then line held high for 200 clocks -> rx_done_o never asserts; data_o=8'h00, flags 0.
- Send 8'hA5 as 8N1, 10 clk/bit -> rx_done_o for exactly 1 cycle at edge 98; data_o=8'hA5; frame_err_o=0.
- Send 8'h3C immediately followed by 8'hC3, no idle gap -> two strobes 100 clocks apart; data_o=8'h3C, then 8'hC3.
- 3-clock low glitch on an idle line -> no strobe; next valid 8'h55 frame is received correctly.
- 8'hFF with stop bit driven low, line held low for 50 more clocks -> one strobe with frame_err_o=1; no second strobe until the line goes high and then low again.
- Assert rst_n low at data bit 4, release, send 8'h81 -> outputs cleared during reset; the next strobe gives data_o=8'h81.
- With UART_RX_PARITY_EN, send 8'h07 with parity bit 1 -> parity_err_o=0, strobe at edge 108. Repeat with parity bit 0 -> parity_err_o=1.
